// File: rtl/cram_soc_lite.sv
`timescale 1ns/1ps
// cram_soc_lite: minimal simulation SoC shell. Latches a boot vector at reset,
// announces it on the UART, refreshes a Sharp-style memory LCD over 3-wire SPI,
// offers a bypass-only JTAG path and raises run status flags for the CI bench.
module cram_soc_lite #(
    parameter logic [31:0] DEFAULT_RESET_VECTOR = 32'h8000_0000,
    parameter int          CLKS_PER_BIT         = 104,
    parameter int          SPI_DIV              = 6,
    parameter int          LPCLK_FRAMES         = 4
) (
    input  logic        clk12,
    input  logic        reset,
    input  logic        lpclk,
    input  logic        jtag_cpu_tck,
    input  logic        jtag_cpu_tms,
    input  logic        jtag_cpu_tdi,
    input  logic        jtag_cpu_trst,
    output logic        jtag_cpu_tdo,
    input  logic        serial_rx,
    output logic        serial_tx,
    output logic        lcd_sclk,
    output logic        lcd_si,
    output logic        lcd_scs,
    input  logic [31:0] trimming_reset,
    input  logic        trimming_reset_ena,
    output logic        sim_coreuser,
    output logic        sim_success,
    output logic        sim_done,
    output logic        sim_report
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] DIV_LAST  = 16'(SPI_DIV - 1);
    localparam logic [15:0] LP_LAST   = 16'(LPCLK_FRAMES - 1);

    // Bit positions inside the synchronizer vectors
    localparam int SY_LP   = 0;
    localparam int SY_TCK  = 1;
    localparam int SY_TMS  = 2;
    localparam int SY_TDI  = 3;
    localparam int SY_TRST = 4;
    localparam int SY_RX   = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_UART,
        S_LCD,
        S_DONE
    } state_t;

    state_t state = S_IDLE;
    state_t state_next;

    logic [5:0]  sync_q1    = 6'b100000;
    logic [5:0]  sync_q2    = 6'b100000;
    logic        lp_prev    = 1'b0;
    logic        tck_prev   = 1'b0;

    logic [31:0] vec        = DEFAULT_RESET_VECTOR;
    logic        coreuser_q = 1'b0;
    logic        done_q     = 1'b0;
    logic        success_q  = 1'b0;
    logic        report_q   = 1'b0;
    logic        rx_ok      = 1'b1;

    logic [15:0] baud_cnt   = 16'd0;
    logic [3:0]  bit_idx    = 4'd0;
    logic [1:0]  byte_idx   = 2'd0;

    logic [15:0] div_cnt    = 16'd0;
    logic [5:0]  half_idx   = 6'd0;
    logic        vcom       = 1'b0;
    logic [15:0] lp_cnt     = 16'd0;

    logic        byp        = 1'b0;
    logic        tdo_q      = 1'b0;

    logic        lp_rise;
    logic        tck_rise;
    logic        tck_fall;
    logic        uart_bit_end;
    logic        uart_byte_end;
    logic        uart_last;
    logic        lcd_half_end;
    logic        lcd_last;
    logic        refresh;
    logic [7:0]  cur_byte;
    logic [3:0]  data_pos;
    logic        tx_bit;
    logic [15:0] lcd_frame;
    logic        unused_tms;

    assign unused_tms = sync_q2[SY_TMS];

    assign lp_rise  = sync_q2[SY_LP] & ~lp_prev;
    assign tck_rise = sync_q2[SY_TCK] & ~tck_prev;
    assign tck_fall = ~sync_q2[SY_TCK] & tck_prev;

    assign uart_bit_end  = (state == S_UART) && (baud_cnt == BAUD_LAST);
    assign uart_byte_end = uart_bit_end && (bit_idx == 4'd9);
    assign uart_last     = uart_byte_end && (byte_idx == 2'd3);
    assign lcd_half_end  = (state == S_LCD) && (div_cnt == DIV_LAST);
    assign lcd_last      = lcd_half_end && (half_idx == 6'd32);
    assign refresh       = (state == S_DONE) && lp_rise && (lp_cnt == LP_LAST);

    assign lcd_frame = {1'b1, vcom, 6'b000000, 8'h00};
    assign data_pos  = bit_idx - 4'd1;

    assign sim_coreuser = coreuser_q;
    assign sim_success  = success_q;
    assign sim_done     = done_q;
    assign sim_report   = report_q;
    assign jtag_cpu_tdo = tdo_q;

    // Two-flop synchronizers for every asynchronous input plus edge history
    always_ff @(posedge clk12) begin
        sync_q1  <= {serial_rx, jtag_cpu_trst, jtag_cpu_tdi, jtag_cpu_tms, jtag_cpu_tck, lpclk};
        sync_q2  <= sync_q1;
        lp_prev  <= sync_q2[SY_LP];
        tck_prev <= sync_q2[SY_TCK];
    end

    // Boot vector and its origin are captured only while reset is held
    always_ff @(posedge clk12) begin
        if (reset) begin
            vec        <= trimming_reset_ena ? trimming_reset : DEFAULT_RESET_VECTOR;
            coreuser_q <= trimming_reset_ena;
        end
    end

    // Sequencer state register
    always_ff @(posedge clk12) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Picks the byte of the boot vector currently on the wire, MSB byte first
    always_comb begin
        cur_byte = vec[31:24];
        case (byte_idx)
            2'd0:    cur_byte = vec[31:24];
            2'd1:    cur_byte = vec[23:16];
            2'd2:    cur_byte = vec[15:8];
            default: cur_byte = vec[7:0];
        endcase
        tx_bit = 1'b1;
        if (bit_idx == 4'd0)      tx_bit = 1'b0;
        else if (bit_idx < 4'd9)  tx_bit = cur_byte[data_pos[2:0]];
        else                      tx_bit = 1'b1;
    end

    // Next-state logic and pin decode; SPI lines only move inside an LCD frame
    always_comb begin
        state_next = state;
        serial_tx  = 1'b1;
        lcd_scs    = 1'b0;
        lcd_sclk   = 1'b0;
        lcd_si     = 1'b0;
        case (state)
            S_IDLE: state_next = S_UART;
            S_UART: begin
                serial_tx = tx_bit;
                if (uart_last) state_next = S_LCD;
            end
            S_LCD: begin
                lcd_scs  = 1'b1;
                lcd_sclk = half_idx[0];
                lcd_si   = ~half_idx[5] & lcd_frame[4'd15 - half_idx[4:1]];
                if (lcd_last) state_next = S_DONE;
            end
            S_DONE: begin
                if (refresh) state_next = S_LCD;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // UART bit timing: baud counter, bit within frame, byte within vector
    always_ff @(posedge clk12) begin
        if (reset || state != S_UART) begin
            baud_cnt <= 16'd0;
            bit_idx  <= 4'd0;
            byte_idx <= 2'd0;
        end else if (uart_bit_end) begin
            baud_cnt <= 16'd0;
            if (bit_idx == 4'd9) begin
                bit_idx  <= 4'd0;
                byte_idx <= byte_idx + 2'd1;
            end else begin
                bit_idx <= bit_idx + 4'd1;
            end
        end else begin
            baud_cnt <= baud_cnt + 16'd1;
        end
    end

    // LCD frame timing in half-periods: 0 is CS setup, 1..31 sclk, 32 CS hold
    always_ff @(posedge clk12) begin
        if (reset || state != S_LCD) begin
            div_cnt  <= 16'd0;
            half_idx <= 6'd0;
        end else if (lcd_half_end) begin
            div_cnt  <= 16'd0;
            half_idx <= half_idx + 6'd1;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

    // VCOM alternates every frame; lpclk edges are only counted while idle in DONE
    always_ff @(posedge clk12) begin
        if (reset) begin
            vcom   <= 1'b0;
            lp_cnt <= 16'd0;
        end else begin
            if (lcd_last) vcom <= ~vcom;
            if (state == S_DONE && lp_rise) begin
                if (lp_cnt == LP_LAST) lp_cnt <= 16'd0;
                else                   lp_cnt <= lp_cnt + 16'd1;
            end
        end
    end

    // Run status: byte-complete pulse, receive-line watchdog, sticky done/success
    always_ff @(posedge clk12) begin
        if (reset) begin
            done_q    <= 1'b0;
            success_q <= 1'b0;
            report_q  <= 1'b0;
            rx_ok     <= 1'b1;
        end else begin
            report_q <= uart_byte_end;
            if (!sync_q2[SY_RX]) rx_ok <= 1'b0;
            if (lcd_last && !done_q) begin
                done_q    <= 1'b1;
                success_q <= rx_ok & sync_q2[SY_RX];
            end
        end
    end

    // One-bit JTAG bypass: capture on tck rise, shift out on tck fall
    always_ff @(posedge clk12) begin
        if (reset || sync_q2[SY_TRST]) begin
            byp   <= 1'b0;
            tdo_q <= 1'b0;
        end else begin
            if (tck_rise) byp   <= sync_q2[SY_TDI];
            if (tck_fall) tdo_q <= byp;
        end
    end

endmodule

// File: tb/tb_cram_soc_lite.sv
`timescale 1ns/1ps
// Testbench for cram_soc_lite: vector table with random rows, UART/SPI monitors
// decoding the pins, and hand sequences for refresh, JTAG bypass and mid-run reset.
module tb_cram_soc_lite;

    localparam logic [31:0] DEF_VEC = 32'h8000_0000;
    localparam int CPB  = 104;
    localparam int SDIV = 6;
    localparam int LPF  = 4;

    logic        clk12 = 1'b0;
    logic        reset = 1'b1;
    logic        lpclk = 1'b0;
    logic        jtag_cpu_tck = 1'b0;
    logic        jtag_cpu_tms = 1'b0;
    logic        jtag_cpu_tdi = 1'b0;
    logic        jtag_cpu_trst = 1'b0;
    logic        jtag_cpu_tdo;
    logic        serial_rx = 1'b1;
    logic        serial_tx;
    logic        lcd_sclk;
    logic        lcd_si;
    logic        lcd_scs;
    logic [31:0] trimming_reset = 32'h0;
    logic        trimming_reset_ena = 1'b0;
    logic        sim_coreuser;
    logic        sim_success;
    logic        sim_done;
    logic        sim_report;

    cram_soc_lite #(
        .DEFAULT_RESET_VECTOR(DEF_VEC),
        .CLKS_PER_BIT(CPB),
        .SPI_DIV(SDIV),
        .LPCLK_FRAMES(LPF)
    ) dut (
        .clk12(clk12),
        .reset(reset),
        .lpclk(lpclk),
        .jtag_cpu_tck(jtag_cpu_tck),
        .jtag_cpu_tms(jtag_cpu_tms),
        .jtag_cpu_tdi(jtag_cpu_tdi),
        .jtag_cpu_trst(jtag_cpu_trst),
        .jtag_cpu_tdo(jtag_cpu_tdo),
        .serial_rx(serial_rx),
        .serial_tx(serial_tx),
        .lcd_sclk(lcd_sclk),
        .lcd_si(lcd_si),
        .lcd_scs(lcd_scs),
        .trimming_reset(trimming_reset),
        .trimming_reset_ena(trimming_reset_ena),
        .sim_coreuser(sim_coreuser),
        .sim_success(sim_success),
        .sim_done(sim_done),
        .sim_report(sim_report)
    );

    always #5 clk12 = ~clk12;

    // Clock cycles since the last cycle in which reset was sampled high
    int cyc = 0;
    always @(posedge clk12) cyc <= reset ? 0 : cyc + 1;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        bit          ena;
        logic [31:0] trim;
        bit          glitch;
        bit          exp_core;
        logic [31:0] exp_vec;
        bit          exp_success;
    } vec_t;

    vec_t tbl [5];
    bit   last_success;

    // UART monitor state
    int          byte_q [$];
    int          rep_q  [$];
    bit          u_act = 1'b0;
    int          u_cnt = 0;
    int          u_k   = 0;
    int          u_first = -1;
    logic [31:0] u_val = 32'h0;

    // SPI monitor state
    int          frame_q [$];
    int          frame_ok_q [$];
    int          spi_glitch = 0;
    bit          s_busy = 1'b0;
    bit          s_ok = 1'b1;
    bit          p_sclk = 1'b0;
    bit          p_si = 1'b0;
    int          s_cnt = 0;
    int          s_first = -1;
    int          s_lastfall = -1;
    int          s_hi = 0;
    int          s_n = 0;
    logic [15:0] s_bits = 16'h0;

    function automatic logic [31:0] bootVector(input bit ena, input logic [31:0] trim);
        return ena ? trim : DEF_VEC;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Decodes 8N1 frames by sampling mid-bit and logs sim_report pulse times
    initial forever begin
        @(negedge clk12);
        if (reset) begin
            u_act = 1'b0;
            u_first = -1;
            byte_q.delete();
            rep_q.delete();
        end else begin
            if (sim_report) rep_q.push_back(cyc);
            if (u_act) begin
                u_cnt++;
                if (u_cnt % CPB == CPB / 2) begin
                    u_k = u_cnt / CPB;
                    if (u_k == 0) begin
                        if (serial_tx) u_val = u_val | 32'h200;
                    end else if (u_k <= 8) begin
                        u_val[u_k - 1] = serial_tx;
                    end else begin
                        if (!serial_tx) u_val = u_val | 32'h100;
                        byte_q.push_back(int'(u_val));
                        u_act = 1'b0;
                    end
                end
            end else if (!serial_tx) begin
                u_act = 1'b1;
                u_cnt = 0;
                u_val = 32'h0;
                if (u_first < 0) u_first = cyc;
            end
        end
    end

    // Captures SPI frames and checks CS setup/hold, half-period and SI stability
    initial forever begin
        @(negedge clk12);
        if (reset) begin
            s_busy = 1'b0;
            frame_q.delete();
            frame_ok_q.delete();
            spi_glitch = 0;
        end else begin
            if (!lcd_scs && !s_busy && (lcd_sclk || lcd_si)) spi_glitch++;
            if (lcd_scs && !s_busy) begin
                s_busy = 1'b1; s_ok = 1'b1; s_cnt = 0; s_first = -1;
                s_lastfall = -1; s_hi = 0; s_n = 0; s_bits = 16'h0;
            end
            if (s_busy) begin
                if (lcd_scs) begin
                    if (lcd_sclk && !p_sclk) begin
                        if (s_first < 0) s_first = s_cnt;
                        s_bits = {s_bits[14:0], lcd_si};
                        s_n++;
                        s_hi = 1;
                    end else if (lcd_sclk) begin
                        s_hi++;
                        if (lcd_si != p_si) s_ok = 1'b0;
                    end else if (p_sclk) begin
                        if (s_hi != SDIV) s_ok = 1'b0;
                        s_lastfall = s_cnt;
                    end
                    s_cnt++;
                end else begin
                    if (s_first != SDIV) s_ok = 1'b0;
                    if (s_cnt - s_lastfall != SDIV) s_ok = 1'b0;
                    if (s_n != 16 || p_sclk) s_ok = 1'b0;
                    frame_q.push_back(int'(s_bits));
                    frame_ok_q.push_back(int'(s_ok));
                    s_busy = 1'b0;
                end
            end
            p_sclk = lcd_sclk;
            p_si = lcd_si;
        end
    end

    task automatic waitDone(input int budget);
        int n = 0;
        while (!sim_done && n < budget) begin
            @(negedge clk12);
            n++;
        end
        checkOutput("done_in_time", sim_done, 1);
        repeat (2) @(negedge clk12);
    endtask

    task automatic waitFrames(input int count, input int budget);
        int n = 0;
        while (frame_q.size() < count && n < budget) begin
            @(negedge clk12);
            n++;
        end
        checkOutput("frame_in_time", frame_q.size(), count);
        @(negedge clk12);
    endtask

    task automatic lpPulse();
        lpclk = 1'b1;
        repeat (8) @(negedge clk12);
        lpclk = 1'b0;
        repeat (8) @(negedge clk12);
    endtask

    // Checks a full boot run against the expected vector and pass/fail grade
    task automatic checkRun(input logic [31:0] v, input bit succ);
        logic [7:0] eb;
        checkOutput("sim_done", sim_done, 1);
        checkOutput("sim_success", sim_success, succ);
        checkOutput("uart_first_start_cycle", u_first, 1);
        checkOutput("uart_byte_count", byte_q.size(), 4);
        checkOutput("report_count", rep_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            eb = v[31 - 8 * i -: 8];
            checkOutput($sformatf("uart_byte%0d", i),
                        (i < byte_q.size()) ? byte_q[i] : -1, {24'h0, eb});
            checkOutput($sformatf("report_cycle%0d", i),
                        (i < rep_q.size()) ? rep_q[i] : -1, 1 + CPB * 10 * (i + 1));
        end
        checkOutput("first_frame", (frame_q.size() > 0) ? frame_q[0] : -1, 32'h8000);
        checkOutput("first_frame_timing", (frame_ok_q.size() > 0) ? frame_ok_q[0] : 0, 1);
        checkOutput("spi_idle_quiet", spi_glitch, 0);
    endtask

    task automatic applyStimulus(input vec_t v);
        trimming_reset     = v.trim;
        trimming_reset_ena = v.ena;
        serial_rx          = 1'b1;
        @(negedge clk12);
        reset = 1'b1;
        repeat (3) @(negedge clk12);
        checkOutput("rst_serial_tx", serial_tx, 1);
        checkOutput("rst_lcd_scs", lcd_scs, 0);
        checkOutput("rst_lcd_sclk", lcd_sclk, 0);
        checkOutput("rst_lcd_si", lcd_si, 0);
        checkOutput("rst_tdo", jtag_cpu_tdo, 0);
        checkOutput("rst_sim_done", sim_done, 0);
        checkOutput("rst_sim_success", sim_success, 0);
        checkOutput("rst_sim_report", sim_report, 0);
        checkOutput("coreuser", sim_coreuser, v.exp_core);
        reset = 1'b0;
        if (v.glitch) begin
            while (cyc < 1500) @(negedge clk12);
            serial_rx = 1'b0;
            repeat (CPB) @(negedge clk12);
            serial_rx = 1'b1;
        end
        waitDone(6000);
        checkRun(v.exp_vec, v.exp_success);
        last_success = v.exp_success;
    endtask

    initial begin
        bit jbits [8];
        bit prev;
        int n;

        tbl[0] = '{ena: 1'b0, trim: 32'h1234_5678, glitch: 1'b0, exp_core: 1'b0,
                   exp_vec: 32'h8000_0000, exp_success: 1'b1};
        tbl[1] = '{ena: 1'b1, trim: 32'h6000_0002, glitch: 1'b0, exp_core: 1'b1,
                   exp_vec: 32'h6000_0002, exp_success: 1'b1};
        tbl[2] = '{ena: 1'b0, trim: 32'hFFFF_FFFF, glitch: 1'b1, exp_core: 1'b0,
                   exp_vec: 32'h8000_0000, exp_success: 1'b0};
        for (int r = 3; r < 5; r++) begin
            tbl[r].ena         = 1'($urandom_range(0, 1));
            tbl[r].trim        = $urandom;
            tbl[r].glitch      = 1'($urandom_range(0, 1));
            tbl[r].exp_core    = tbl[r].ena;
            tbl[r].exp_vec     = bootVector(tbl[r].ena, tbl[r].trim);
            tbl[r].exp_success = !tbl[r].glitch;
        end

        repeat (4) @(negedge clk12);
        for (int r = 0; r < 5; r++) begin
            $display("[TB] row %0d ena=%0d trim=%h glitch=%0d", r, tbl[r].ena, tbl[r].trim, tbl[r].glitch);
            applyStimulus(tbl[r]);
        end

        // Refresh: LPF lpclk rises start a frame with VCOM flipped; rises mid-frame are ignored
        repeat (LPF - 1) lpPulse();
        checkOutput("no_early_refresh", frame_q.size(), 1);
        checkOutput("scs_idle_before_refresh", lcd_scs, 0);
        lpclk = 1'b1;
        n = 0;
        while (!lcd_scs && n < 20) begin
            @(negedge clk12);
            n++;
        end
        checkOutput("refresh_started", lcd_scs, 1);
        repeat (4) @(negedge clk12);
        lpclk = 1'b0;
        repeat (4) @(negedge clk12);
        repeat (LPF - 1) lpPulse();
        waitFrames(2, 400);
        checkOutput("refresh_frame", (frame_q.size() > 1) ? frame_q[1] : -1, 32'hC000);
        checkOutput("refresh_frame_timing", (frame_ok_q.size() > 1) ? frame_ok_q[1] : 0, 1);
        repeat (LPF - 1) lpPulse();
        repeat (10) @(negedge clk12);
        checkOutput("midframe_edges_ignored", frame_q.size(), 2);
        lpPulse();
        waitFrames(3, 400);
        checkOutput("third_frame", (frame_q.size() > 2) ? frame_q[2] : -1, 32'h8000);
        checkOutput("done_sticky", sim_done, 1);
        checkOutput("success_sticky", sim_success, last_success);

        // JTAG bypass: tdo follows the tdi captured on the previous rise, after the fall
        jbits[0] = 1'b1; jbits[1] = 1'b0; jbits[2] = 1'b1; jbits[3] = 1'b1;
        for (int i = 4; i < 7; i++) jbits[i] = 1'($urandom_range(0, 1));
        jbits[7] = 1'b1;
        prev = 1'b0;
        jtag_cpu_trst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            jtag_cpu_tdi = jbits[i];
            jtag_cpu_tms = 1'($urandom_range(0, 1));
            repeat (4) @(negedge clk12);
            jtag_cpu_tck = 1'b1;
            repeat (8) @(negedge clk12);
            checkOutput($sformatf("tdo_hold_after_rise%0d", i), jtag_cpu_tdo, prev);
            jtag_cpu_tdi = ~jbits[i];
            jtag_cpu_tck = 1'b0;
            repeat (8) @(negedge clk12);
            checkOutput($sformatf("tdo_after_fall%0d", i), jtag_cpu_tdo, jbits[i]);
            prev = jbits[i];
        end
        jtag_cpu_trst = 1'b1;
        repeat (8) @(negedge clk12);
        checkOutput("tdo_trst_clear", jtag_cpu_tdo, 0);
        jtag_cpu_trst = 1'b0;
        repeat (4) @(negedge clk12);

        // Reset in the middle of the second UART byte with a new trimmed vector
        trimming_reset_ena = 1'b0;
        @(negedge clk12);
        reset = 1'b1;
        repeat (2) @(negedge clk12);
        reset = 1'b0;
        while (cyc < 1500) @(negedge clk12);
        trimming_reset     = 32'hA5C3_0F96;
        trimming_reset_ena = 1'b1;
        reset = 1'b1;
        @(negedge clk12);
        checkOutput("midreset_serial_tx", serial_tx, 1);
        checkOutput("midreset_report", sim_report, 0);
        checkOutput("midreset_coreuser", sim_coreuser, 1);
        reset = 1'b0;
        waitDone(6000);
        checkRun(32'hA5C3_0F96, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #3ms;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
